// File: rtl/cover_pkg.sv
// Shared constants and helpers for the toggle-coverage collector.
package cover_pkg;

    localparam int MODE_LEVEL = 0;
    localparam int MODE_RISE  = 1;
    localparam int MODE_BOTH  = 2;

    // Both-edge mode tracks rise and fall of every bit as separate points.
    function automatic int points_f(input int width, input int mode);
        return (mode == MODE_BOTH) ? 2 * width : width;
    endfunction

endpackage

// File: rtl/cover_toggle_collector_if.sv
// Report stream from the coverage collector to its drain / host bridge.
interface cover_toggle_collector_if #(
    parameter int INDEX_W = 64
);
    logic               out_valid;
    logic               out_ready;
    logic [INDEX_W-1:0] out_index;

    modport master (output out_valid, output out_index, input out_ready);
    modport slave  (input out_valid, input out_index, output out_ready);
endinterface

// File: rtl/cover_fifo.sv
// Synchronous FIFO for pending cover reports; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module cover_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    // Empty reads as zero so the reported index rests at the base index.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

    always_ff @(posedge clock) begin
        if (!reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky coverage bitmap, one report per newly
// covered point on a valid/ready stream, with hit counter and clear.
module cover_toggle_collector
    import cover_pkg::*;
#(
    parameter int              WIDTH       = 11,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int              INDEX_W     = 64,
    parameter int              MODE        = MODE_LEVEL,
    parameter int              FIFO_DEPTH  = 4,
    localparam int             POINTS      = points_f(WIDTH, MODE),
    localparam int             CNT_W       = $clog2(POINTS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         valid,
    input  logic                     clear,
    cover_toggle_collector_if.master rpt,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     all_covered
);
    localparam int LIDX_W = (POINTS > 1) ? $clog2(POINTS) : 1;

    logic [POINTS-1:0] covered_q, covered_d;
    logic [POINTS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]  hit_count_q, hit_count_d;
    logic              all_covered_q;
    logic [POINTS-1:0] detect, new_hit, pend_sel;
    logic [LIDX_W-1:0] pend_idx, head;
    logic [CNT_W-1:0]  new_cnt;
    logic              push, pop, fifo_full, fifo_empty;

    if (MODE == MODE_LEVEL) begin : g_level
        assign detect = en ? valid : '0;
    end else begin : g_edge
        logic [WIDTH-1:0] prev_q;
        logic             prev_ok_q;
        logic             arm;

        // No edge is seen until prev holds a genuine enabled sample.
        assign arm = en && prev_ok_q;

        if (MODE == MODE_BOTH) begin : g_both
            assign detect = arm ? {prev_q & ~valid, ~prev_q & valid} : '0;
        end else begin : g_rise
            assign detect = arm ? (~prev_q & valid) : '0;
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                prev_q    <= '0;
                prev_ok_q <= 1'b0;
            end else if (clear) begin
                prev_ok_q <= 1'b0;
            end else if (en) begin
                prev_q    <= valid;
                prev_ok_q <= 1'b1;
            end
        end
    end

    assign new_hit  = detect & ~covered_q;
    assign pend_sel = pending_q & (~pending_q + POINTS'(1));

    always_comb begin
        pend_idx = '0;
        for (int p = POINTS - 1; p >= 0; p--) begin
            if (pending_q[p]) pend_idx = LIDX_W'(p);
        end
    end

    always_comb begin
        new_cnt = '0;
        for (int p = 0; p < POINTS; p++) new_cnt = new_cnt + CNT_W'(new_hit[p]);
    end

    assign pop         = !fifo_empty && rpt.out_ready;
    assign push        = (|pending_q) && (!fifo_full || pop);
    assign covered_d   = covered_q | new_hit;
    // New hits never overlap pending bits, since pending is a subset of covered.
    assign pending_d   = (pending_q | new_hit) & ~(push ? pend_sel : '0);
    assign hit_count_d = hit_count_q + new_cnt;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            covered_q     <= '0;
            pending_q     <= '0;
            hit_count_q   <= '0;
            all_covered_q <= 1'b0;
        end else begin
            covered_q     <= covered_d;
            pending_q     <= pending_d;
            hit_count_q   <= hit_count_d;
            all_covered_q <= (hit_count_d == CNT_W'(POINTS));
        end
    end

    cover_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LIDX_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clr       (clear),
        .push      (push),
        .push_data (pend_idx),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rpt.out_valid = !fifo_empty;
    assign rpt.out_index = INDEX_W'(COVER_INDEX) + INDEX_W'(head);
    assign hit_count     = hit_count_q;
    assign all_covered   = all_covered_q;

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector: directed scenarios on four configurations
// plus randomized runs checked against a point-level coverage model.
module tb_cover_toggle_collector;
    import cover_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [10:0] valid = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    longint unsigned got[$];
    int got_cyc[$];

    always #5 clock = ~clock;

    cover_toggle_collector_if #(.INDEX_W(64)) if_a ();
    cover_toggle_collector_if #(.INDEX_W(64)) if_b ();
    cover_toggle_collector_if #(.INDEX_W(64)) if_c ();
    cover_toggle_collector_if #(.INDEX_W(64)) if_d ();
    assign if_a.out_ready = out_ready;
    assign if_b.out_ready = out_ready;
    assign if_c.out_ready = out_ready;
    assign if_d.out_ready = out_ready;

    logic [3:0] hc_a, hc_b, hc_c, hc_d;
    logic       ac_a, ac_b, ac_c, ac_d;

    // a: level, base 100   b: rise   c: both edges, 4 bits   d: level, base 0
    cover_toggle_collector #(.WIDTH(11), .COVER_INDEX(100), .INDEX_W(64),
        .MODE(MODE_LEVEL), .FIFO_DEPTH(4)) dut_a (
        .clock(clock), .reset(reset), .en(en), .valid(valid), .clear(clear),
        .rpt(if_a), .hit_count(hc_a), .all_covered(ac_a));
    cover_toggle_collector #(.WIDTH(11), .COVER_INDEX(0), .INDEX_W(64),
        .MODE(MODE_RISE), .FIFO_DEPTH(4)) dut_b (
        .clock(clock), .reset(reset), .en(en), .valid(valid), .clear(clear),
        .rpt(if_b), .hit_count(hc_b), .all_covered(ac_b));
    cover_toggle_collector #(.WIDTH(4), .COVER_INDEX(0), .INDEX_W(64),
        .MODE(MODE_BOTH), .FIFO_DEPTH(4)) dut_c (
        .clock(clock), .reset(reset), .en(en), .valid(valid[3:0]), .clear(clear),
        .rpt(if_c), .hit_count(hc_c), .all_covered(ac_c));
    cover_toggle_collector #(.WIDTH(11), .COVER_INDEX(0), .INDEX_W(64),
        .MODE(MODE_LEVEL), .FIFO_DEPTH(4)) dut_d (
        .clock(clock), .reset(reset), .en(en), .valid(valid), .clear(clear),
        .rpt(if_d), .hit_count(hc_d), .all_covered(ac_d));

    function automatic longint unsigned base_of(int k);
        return (k == 0) ? 64'd100 : 64'd0;
    endfunction

    function automatic void get_out(input int k, output bit v,
                                    output longint unsigned idx, output int hc,
                                    output bit ac);
        case (k)
            0:       begin v = if_a.out_valid; idx = if_a.out_index; hc = int'(hc_a); ac = ac_a; end
            1:       begin v = if_b.out_valid; idx = if_b.out_index; hc = int'(hc_b); ac = ac_b; end
            2:       begin v = if_c.out_valid; idx = if_c.out_index; hc = int'(hc_c); ac = ac_c; end
            default: begin v = if_d.out_valid; idx = if_d.out_index; hc = int'(hc_d); ac = ac_d; end
        endcase
    endfunction

    // Outputs depend only on state, so sampling after driving is safe.
    task automatic tick(input int k);
        bit v; longint unsigned idx; int hc; bit ac;
        get_out(k, v, idx, hc, ac);
        if (v && out_ready && reset && !clear) begin
            got.push_back(idx);
            got_cyc.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run(input int k, input int n);
        for (int i = 0; i < n; i++) tick(k);
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; clear = 1'b0; valid = '0; out_ready = 1'b0;
        run(0, 2);
        reset = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        bit v; longint unsigned idx; int hc; bit ac;
        reset = 1'b0; en = 1'b1; clear = 1'b1; valid = '1; out_ready = 1'b1;
        run(0, 3);
        for (int k = 0; k < 4; k++) begin
            get_out(k, v, idx, hc, ac);
            checks++; if (v !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d got %0d want 0", k, v); end
            checks++; if (idx !== base_of(k)) begin errors++; $display("FAIL reset_index dut%0d got %0d want %0d", k, idx, base_of(k)); end
            checks++; if (hc !== 0) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", k, hc); end
            checks++; if (ac !== 1'b0) begin errors++; $display("FAIL reset_all dut%0d got %0d want 0", k, ac); end
        end
        reset = 1'b1; clear = 1'b0; en = 1'b0; valid = '0; out_ready = 1'b0;
    endtask

    task automatic test_level();
        bit v; longint unsigned idx; int hc; bit ac;
        longint unsigned exp[2] = '{100, 102};
        do_reset();
        out_ready = 1'b1; en = 1'b1; valid = 11'h005;
        tick(0);
        get_out(0, v, idx, hc, ac);
        checks++; if (hc !== 2 || v !== 1'b0) begin errors++; $display("FAIL level_first_edge got count %0d valid %0d want 2 0", hc, v); end
        tick(0);
        get_out(0, v, idx, hc, ac);
        checks++; if (v !== 1'b1 || idx !== 100) begin errors++; $display("FAIL level_latency got valid %0d idx %0d want 1 100", v, idx); end
        run(0, 3);
        valid = '0;
        run(0, 6);
        get_out(0, v, idx, hc, ac);
        checks++; if (got.size() != 2) begin errors++; $display("FAIL level_count_reports got %0d want 2", got.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== exp[i]) begin
                errors++; $display("FAIL level_report%0d got %0d want %0d", i, (got.size() > i) ? got[i] : 64'hFFFF, exp[i]);
            end
        end
        checks++; if (hc !== 2) begin errors++; $display("FAIL level_hit_count got %0d want 2", hc); end
    endtask

    task automatic test_rise();
        bit v; longint unsigned idx; int hc; bit ac;
        do_reset();
        out_ready = 1'b1; en = 1'b1; valid = 11'h008;
        tick(1);
        valid = '0;
        tick(1);
        get_out(1, v, idx, hc, ac);
        checks++; if (hc !== 0 || got.size() != 0) begin errors++; $display("FAIL rise_no_first_edge got count %0d reports %0d want 0 0", hc, got.size()); end
        valid = 11'h008;
        tick(1);
        get_out(1, v, idx, hc, ac);
        checks++; if (hc !== 1) begin errors++; $display("FAIL rise_hit_count got %0d want 1", hc); end
        run(1, 6);
        checks++;
        if (got.size() != 1 || got[0] !== 3) begin
            errors++; $display("FAIL rise_report got n=%0d first %0d want n=1 3", got.size(), (got.size() > 0) ? got[0] : 64'hFFFF);
        end
    endtask

    task automatic test_both();
        bit v; longint unsigned idx; int hc; bit ac;
        bit seen[8];
        do_reset();
        out_ready = 1'b1; en = 1'b1; valid = '0;
        tick(2);
        valid = 11'h002; tick(2);
        valid = '0;      tick(2);
        run(2, 5);
        get_out(2, v, idx, hc, ac);
        checks++;
        if (got.size() != 2 || got[0] !== 1 || got[1] !== 5) begin
            errors++; $display("FAIL both_reports got n=%0d want 1 then 5", got.size());
        end
        checks++; if (hc !== 2 || ac !== 1'b0) begin errors++; $display("FAIL both_partial got count %0d all %0d want 2 0", hc, ac); end
        valid = 11'h00F; tick(2);
        valid = '0;      tick(2);
        run(2, 12);
        get_out(2, v, idx, hc, ac);
        checks++; if (hc !== 8 || ac !== 1'b1) begin errors++; $display("FAIL both_all_covered got count %0d all %0d want 8 1", hc, ac); end
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        foreach (got[i]) if (got[i] < 8) seen[got[i]] = 1'b1;
        checks++;
        if (got.size() != 8 || !(seen[0] && seen[1] && seen[2] && seen[3] && seen[4] && seen[5] && seen[6] && seen[7])) begin
            errors++; $display("FAIL both_all_reports got n=%0d want 8 distinct", got.size());
        end
    endtask

    task automatic test_back_pressure();
        bit v; longint unsigned idx; int hc; bit ac;
        bit stable = 1'b1;
        do_reset();
        out_ready = 1'b0; en = 1'b1; valid = 11'h7FF;
        for (int i = 0; i < 20; i++) begin
            tick(3);
            get_out(3, v, idx, hc, ac);
            if (i >= 1 && (v !== 1'b1 || idx !== 0)) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_stall_hold got valid %0d idx %0d want 1 0", v, idx); end
        checks++; if (hc !== 11 || ac !== 1'b1) begin errors++; $display("FAIL bp_count got %0d all %0d want 11 1", hc, ac); end
        out_ready = 1'b1;
        run(3, 16);
        checks++; if (got.size() != 11) begin errors++; $display("FAIL bp_total got %0d want 11", got.size()); end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== longint'(i) || got_cyc[i] != got_cyc[0] + i) begin
                errors++; $display("FAIL bp_order%0d got %0d want %0d back to back", i, (got.size() > i) ? got[i] : 64'hFFFF, i);
            end
        end
        get_out(3, v, idx, hc, ac);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL bp_drained got %0d want 0", v); end
    endtask

    task automatic test_clear();
        bit v; longint unsigned idx; int hc; bit ac;
        do_reset();
        out_ready = 1'b0; en = 1'b1; valid = 11'h007;
        run(0, 4);
        get_out(0, v, idx, hc, ac);
        checks++; if (v !== 1'b1 || hc !== 3) begin errors++; $display("FAIL clear_pre got valid %0d count %0d want 1 3", v, hc); end
        clear = 1'b1;
        tick(0);
        clear = 1'b0;
        get_out(0, v, idx, hc, ac);
        checks++; if (v !== 1'b0 || hc !== 0) begin errors++; $display("FAIL clear_flush got valid %0d count %0d want 0 0", v, hc); end
        out_ready = 1'b1;
        run(0, 8);
        checks++;
        if (got.size() != 3 || got[0] !== 100 || got[1] !== 101 || got[2] !== 102) begin
            errors++; $display("FAIL clear_rereport got n=%0d want 100 101 102", got.size());
        end
    endtask

    task automatic test_reset_mid();
        bit v; longint unsigned idx; int hc; bit ac;
        do_reset();
        out_ready = 1'b0; en = 1'b1; valid = '0;
        tick(1);
        valid = 11'h7FF;
        run(1, 4);
        get_out(1, v, idx, hc, ac);
        checks++; if (v !== 1'b1 || hc !== 11) begin errors++; $display("FAIL rmid_pre got valid %0d count %0d want 1 11", v, hc); end
        reset = 1'b0; clear = 1'b1;
        tick(1);
        get_out(1, v, idx, hc, ac);
        checks++;
        if (v !== 1'b0 || idx !== 0 || hc !== 0 || ac !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs got valid %0d idx %0d count %0d all %0d want 0 0 0 0", v, idx, hc, ac);
        end
        reset = 1'b1; clear = 1'b0;
        run(1, 2);
        get_out(1, v, idx, hc, ac);
        checks++; if (hc !== 0) begin errors++; $display("FAIL rmid_no_edge got %0d want 0", hc); end
        valid = '0;      tick(1);
        valid = 11'h7FF; tick(1);
        get_out(1, v, idx, hc, ac);
        checks++; if (hc !== 11) begin errors++; $display("FAIL rmid_rearm got %0d want 11", hc); end
    endtask

    task automatic test_random(input int k, input int mode, input int width, input int ncyc);
        bit v, pv, pready, pclr, ac, hit, x;
        longint unsigned idx, pidx, p;
        int hc, points, cnt, b;
        bit cov[32];
        bit rep[32];
        bit prv[16];
        bit pok;
        points = (mode == MODE_BOTH) ? 2 * width : width;
        for (int i = 0; i < 32; i++) begin cov[i] = 1'b0; rep[i] = 1'b0; end
        for (int i = 0; i < 16; i++) prv[i] = 1'b0;
        pok = 1'b0; cnt = 0; pv = 1'b0; pidx = 0; pready = 1'b0; pclr = 1'b0;
        do_reset();
        for (int c = 0; c < ncyc + 40; c++) begin
            if (c >= ncyc) begin
                en = 1'b0; clear = 1'b0; out_ready = 1'b1;
            end else begin
                en        = ($urandom_range(0, 9) != 0);
                clear     = ($urandom_range(0, 59) == 0);
                out_ready = ($urandom_range(0, 2) != 0);
                valid     = valid ^ (11'($urandom) & 11'($urandom));
            end
            get_out(k, v, idx, hc, ac);
            checks++;
            if (hc !== cnt || ac !== (cnt == points)) begin
                errors++; $display("FAIL rnd%0d_count cyc %0d got %0d/%0d want %0d/%0d", k, c, hc, ac, cnt, cnt == points);
            end
            if (pv && !pready && !pclr) begin
                checks++;
                if (v !== 1'b1 || idx !== pidx) begin
                    errors++; $display("FAIL rnd%0d_stall cyc %0d got %0d/%0d want 1/%0d", k, c, v, idx, pidx);
                end
            end
            if (v && out_ready && !clear) begin
                p = idx - base_of(k);
                checks++;
                if (p >= longint'(points) || !cov[p] || rep[p]) begin
                    errors++; $display("FAIL rnd%0d_report cyc %0d got %0d want new covered point", k, c, idx);
                end else rep[p] = 1'b1;
            end
            pv = v; pidx = idx; pready = out_ready; pclr = clear;
            if (clear) begin
                for (int i = 0; i < 32; i++) begin cov[i] = 1'b0; rep[i] = 1'b0; end
                cnt = 0; pok = 1'b0;
            end else if (en) begin
                for (int q = 0; q < points; q++) begin
                    b = q % width;
                    x = valid[b];
                    if (mode == MODE_LEVEL) hit = x;
                    else if (q < width)     hit = pok && !prv[b] && x;
                    else                    hit = pok && prv[b] && !x;
                    if (hit && !cov[q]) begin cov[q] = 1'b1; cnt++; end
                end
                for (int i = 0; i < width; i++) prv[i] = valid[i];
                pok = 1'b1;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        for (int q = 0; q < points; q++) begin
            checks++;
            if (cov[q] !== rep[q]) begin
                errors++; $display("FAIL rnd%0d_final point %0d got reported %0d want %0d", k, q, rep[q], cov[q]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_rise();
        test_both();
        test_back_pressure();
        test_clear();
        test_reset_mid();
        test_random(2, MODE_BOTH, 4, 400);
        test_random(1, MODE_RISE, 11, 400);
        test_random(0, MODE_LEVEL, 11, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cover_toggle_collector.md
# cover_toggle_collector

Parametrised toggle-coverage collector for the formal/fuzz coverage flow. It samples a vector of coverage signals and records each coverage point once, in a sticky bitmap. Each newly covered point is reported exactly once as a global cover index on a valid/ready stream. A downstream drain or host bridge consumes the stream, and back-pressure never loses a hit. It replaces per-cycle, per-bit report calls and adds edge modes, deduplication, buffering, a hit counter and a clear.

## Interface
- WIDTH, 11: number of sampled input bits.
- COVER_INDEX, 0: global index of local point 0.
- INDEX_W, 64: width of the reported index.
- MODE, 0: 0 = level (bit high counts as a hit), 1 = rising edge, 2 = both edges.
- FIFO_DEPTH, 4: report FIFO entries, power of two, ≥2.
- Derived POINTS: WIDTH for modes 0/1, 2*WIDTH for mode 2.
  - In mode 2, point p<WIDTH is the rise of bit p; point WIDTH+p is the fall of bit p.
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low; clock clock.
- en  in  1  sampling enable.
- valid  in  WIDTH  coverage signals.
- clear  in  1  synchronous clear of coverage state.
- out_valid  out  1  report available.
- out_ready  in  1  consumer accepts.
- out_index  out  INDEX_W  COVER_INDEX + local point.
- hit_count  out  $clog2(POINTS+1)  number of covered points.
- all_covered  out  1  hit_count == POINTS.

## Operation
- State:
  - prev: sampled valid.
  - prev_ok: prev holds a real sample.
  - covered[POINTS]: sticky.
  - pending[POINTS]: covered, not yet queued.
  - FIFO of local indices.
  - hit_count.
- Detection only when en=1:
  - Mode 0: valid[p].
  - Mode 1: prev_ok & ~prev[p] & valid[p].
  - Mode 2: rise as in mode 1; fall = prev_ok & prev[p] & ~valid[p].
- prev and prev_ok update:
  - When en=1: prev<=valid and prev_ok<=1.
  - When en=0: prev and prev_ok hold.
  - The first enabled cycle after reset or clear never produces an edge.
- New hit on p when detect[p] & ~covered[p]. On a new hit, set covered[p] and pending[p].
- hit_count adds the popcount of new hits in the same cycle.
- Queueing, one push per cycle at most:
  - Push the lowest-numbered set pending bit p into the FIFO and clear pending[p].
  - A push is permitted when the FIFO is not full, or when it is full and a pop occurs the same cycle.
  - A new hit on bit q and a push of bit p in the same cycle both take effect. q ≠ p always holds.
- Output:
  - out_valid = FIFO not empty.
  - out_index = COVER_INDEX + head, zero-extended to INDEX_W.
  - Pop on out_valid & out_ready.
- Back-pressure: pending bits wait indefinitely. No hit is dropped or duplicated.
- clear=1 (reset=1):
  - Zero covered, pending, FIFO, hit_count and prev_ok.
  - Detection in that cycle is discarded.
- reset=0: same as clear, and also prev<=0. Reset overrides clear.

## Timing
- Reset values: out_valid=0, out_index=COVER_INDEX, hit_count=0, all_covered=0.
- Latency: a hit sampled at edge N sets covered and pending at N. It is pushed at N+1, so out_valid=1 after edge N+1, provided the FIFO has space and no lower pending bit exists.
- hit_count and all_covered are registered. They reflect a hit after the same edge that sets covered.
- out_index stays stable while out_valid=1 & out_ready=0.
- Throughput: 1 report/cycle sustained.
- Reset or clear mid-drain: the stream empties on the next edge. Unreported indices are lost by design.

## Structure
- Package cover_pkg holds:
  - MODE_LEVEL/MODE_RISE/MODE_BOTH constants.
  - A points_f(width, mode) function.
- Sub-module cover_fifo: synchronous FIFO, parameters DEPTH and W, with push/pop/full/empty and same-cycle push+pop when full.
- The lowest-set-bit priority encoder and the popcount stay inline.
- The block contains no DPI.

## Test plan
- Mode 0, WIDTH=11, COVER_INDEX=100, valid=0x005 held 5 cycles, out_ready=1:
  - Exactly indices 100 then 102 are reported.
  - hit_count=2.
  - No repeats.
- Mode 1, valid bit3 high on the first enabled cycle, then low, then high:
  - Only one report, index 3, after the second rise.
- Mode 2, WIDTH=4, bit1 0→1→0:
  - Reports 1 then 5.
  - hit_count=2; after all 8 edges have occurred, all_covered=1.
- out_ready=0 for 20 cycles, valid=0x7FF, FIFO_DEPTH=4:
  - Four entries are queued and the remaining 7 stay pending.
  - After out_ready is raised, indices 0..10 arrive in order with no gap cycles and no loss.
- clear pulsed while 3 entries are queued:
  - out_valid=0 and hit_count=0 on the next edge.
  - Re-asserting the same valid bits re-reports them.
- reset=0 asserted mid-operation with en=1 and clear=1 simultaneously:
  - All outputs return to reset values.
  - The first cycle after reset releases produces no edge hits in mode 1.
